// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, control bundle layout and decode helpers.
package mips_pkg;

    // Control bundle, MSB first: regwrite,memread,memwrite,memtoreg,alusrc,regdst,branch,aluop[1:0]
    localparam int unsigned CTRL_W        = 9;
    localparam int unsigned CTRL_REGWRITE = 8;
    localparam int unsigned CTRL_MEMREAD  = 7;
    localparam int unsigned CTRL_MEMWRITE = 6;
    localparam int unsigned CTRL_MEMTOREG = 5;
    localparam int unsigned CTRL_ALUSRC   = 4;
    localparam int unsigned CTRL_REGDST   = 3;
    localparam int unsigned CTRL_BRANCH   = 2;
    localparam int unsigned CTRL_ALUOP_HI = 1;
    localparam int unsigned CTRL_ALUOP_LO = 0;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instructions that actually read rt as a source operand.
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic op_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of the ID instruction.
module hazard_detect #(
    parameter int unsigned REG_ADDR_W         = 5,
    parameter bit          ZERO_REG_HARDWIRED = 1'b0
) (
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_memread,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  rt_used,
    output logic                  hazard
);

    logic load_in_ex;
    logic dest_is_zero;

    assign load_in_ex   = ex_valid && ex_memread;
    // A load into a hardwired $0 never produces a value anyone can depend on.
    assign dest_is_zero = ZERO_REG_HARDWIRED && (ex_rt == '0);
    assign hazard       = load_in_ex && !dest_is_zero &&
                          ((ex_rt == rs) || (rt_used && (ex_rt == rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, immediate extension and load-use bubble insertion.
module id_ex_stage #(
    parameter int unsigned DATA_W             = 32,
    parameter int unsigned REG_ADDR_W         = 5,
    parameter int unsigned CTRL_W             = mips_pkg::CTRL_W,
    parameter bit          ZERO_REG_HARDWIRED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    input  logic [31:0]           id_pc4,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [DATA_W-1:0]     rd1_in,
    input  logic [DATA_W-1:0]     rd2_in,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  flush,
    output logic                  stall_out,
    output logic                  ex_valid,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [31:0]           ex_pc4
);

    import mips_pkg::*;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rs_val;
    logic [DATA_W-1:0]     rt_val;
    logic [DATA_W-1:0]     imm_ext;
    logic                  rt_used;
    logic                  load_use;
    logic                  hazard;
    logic                  bubble;

    assign opcode  = id_instr[31:26];
    assign rs      = REG_ADDR_W'(id_instr[25:21]);
    assign rt      = REG_ADDR_W'(id_instr[20:16]);
    assign rd      = REG_ADDR_W'(id_instr[15:11]);
    assign rt_used = op_uses_rt(opcode);

    // The register file does not forward a same-cycle write, so bypass it here.
    always_comb begin
        rs_val = rd1_in;
        rt_val = rd2_in;
        if (wb_regwrite && (wb_reg == rs) && !(ZERO_REG_HARDWIRED && (rs == '0))) begin
            rs_val = wb_data;
        end
        if (wb_regwrite && (wb_reg == rt) && !(ZERO_REG_HARDWIRED && (rt == '0))) begin
            rt_val = wb_data;
        end
    end

    always_comb begin
        if (op_zero_ext(opcode)) begin
            imm_ext = {{(DATA_W-16){1'b0}}, id_instr[15:0]};
        end else begin
            imm_ext = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
        end
    end

    hazard_detect #(
        .REG_ADDR_W         (REG_ADDR_W),
        .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_hazard_detect (
        .ex_rt      (ex_rt),
        .ex_memread (ex_ctrl[CTRL_MEMREAD]),
        .ex_valid   (ex_valid),
        .rs         (rs),
        .rt         (rt),
        .rt_used    (rt_used),
        .hazard     (load_use)
    );

    assign hazard    = load_use && id_valid;
    // A flush squashes the dependent instruction anyway, so there is nothing to wait for.
    assign stall_out = hazard && !flush;
    assign bubble    = flush || hazard || !id_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= BUBBLE_CTRL;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_pc4     <= '0;
        end else if (bubble) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= BUBBLE_CTRL;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_pc4     <= '0;
        end else begin
            ex_valid   <= 1'b1;
            ex_ctrl    <= id_ctrl;
            ex_rs_data <= rs_val;
            ex_rt_data <= rt_val;
            ex_imm     <= imm_ext;
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_rd      <= rd;
            ex_pc4     <= id_pc4;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_stage;

    import mips_pkg::*;

    localparam bit HW = 1'b0;

    localparam logic [8:0] C_LW   = 9'h1B0;
    localparam logic [8:0] C_RTYP = 9'h10A;
    localparam logic [8:0] C_ADDI = 9'h110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid, wb_regwrite, flush;
    logic [31:0] id_instr, id_pc4, rd1_in, rd2_in, wb_data;
    logic [8:0]  id_ctrl;
    logic [4:0]  wb_reg;
    logic        stall_out, ex_valid;
    logic [8:0]  ex_ctrl;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;

    id_ex_stage #(
        .DATA_W             (32),
        .REG_ADDR_W         (5),
        .CTRL_W             (9),
        .ZERO_REG_HARDWIRED (HW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_ctrl     (id_ctrl),
        .rd1_in      (rd1_in),
        .rd2_in      (rd2_in),
        .wb_regwrite (wb_regwrite),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .flush       (flush),
        .stall_out   (stall_out),
        .ex_valid    (ex_valid),
        .ex_ctrl     (ex_ctrl),
        .ex_rs_data  (ex_rs_data),
        .ex_rt_data  (ex_rt_data),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_pc4      (ex_pc4)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model of what EX should hold.
    logic        m_valid;
    logic [8:0]  m_ctrl;
    logic [31:0] m_rs_data, m_rt_data, m_imm, m_pc4;
    logic [4:0]  m_rs, m_rt, m_rd;

    function automatic logic [152:0] dut_bundle();
        return {ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_pc4};
    endfunction

    function automatic logic [152:0] model_bundle();
        return {m_valid, m_ctrl, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_rd, m_pc4};
    endfunction

    task automatic model_clear();
        m_valid = 0; m_ctrl = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_pc4 = 0;
    endtask

    function automatic bit ref_hazard();
        logic [5:0] op = id_instr[31:26];
        logic [4:0] s  = id_instr[25:21];
        logic [4:0] t  = id_instr[20:16];
        bit reads_rt   = op inside {6'h00, 6'h04, 6'h05, 6'h2B};
        if (!(m_valid && m_ctrl[CTRL_MEMREAD] && id_valid)) return 0;
        if (HW && m_rt == 0) return 0;
        return (m_rt == s) || (reads_rt && m_rt == t);
    endfunction

    function automatic logic [31:0] ref_src(input logic [4:0] r, input logic [31:0] rf);
        if (wb_regwrite && wb_reg == r && !(HW && r == 0)) return wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        if (ins[31:26] inside {6'h0C, 6'h0D, 6'h0E}) return {16'h0000, ins[15:0]};
        return ins[15] ? {16'hFFFF, ins[15:0]} : {16'h0000, ins[15:0]};
    endfunction

    // Advance one clock and move the model to what EX should now contain.
    task automatic cycle();
        bit          take = !(flush || ref_hazard() || !id_valid);
        logic [31:0] s_v  = ref_src(id_instr[25:21], rd1_in);
        logic [31:0] t_v  = ref_src(id_instr[20:16], rd2_in);
        @(posedge clk);
        #1;
        if (take) begin
            m_valid = 1; m_ctrl = id_ctrl; m_rs_data = s_v; m_rt_data = t_v;
            m_imm = ref_imm(id_instr); m_rs = id_instr[25:21]; m_rt = id_instr[20:16];
            m_rd = id_instr[15:11]; m_pc4 = id_pc4;
        end else begin
            model_clear();
        end
    endtask

    task automatic set_idle();
        id_valid = 0; id_instr = 0; id_pc4 = 0; id_ctrl = 0; rd1_in = 0; rd2_in = 0;
        wb_regwrite = 0; wb_reg = 0; wb_data = 0; flush = 0;
    endtask

    task automatic drive_id(input logic [31:0] ins, input logic [8:0] c, input logic [31:0] pc4,
                            input logic [31:0] r1, input logic [31:0] r2);
        id_valid = 1; id_instr = ins; id_ctrl = c; id_pc4 = pc4; rd1_in = r1; rd2_in = r2;
    endtask

    task automatic test_reset();
        id_valid = 1; id_instr = $urandom; id_pc4 = $urandom; id_ctrl = 9'($urandom);
        rd1_in = $urandom; rd2_in = $urandom; wb_regwrite = 1; wb_reg = 5'($urandom);
        wb_data = $urandom; flush = 0;
        #2 rst = 0;
        #1;
        model_clear();
        n_total++;
        if (dut_bundle() !== 153'd0) $display("FAIL reset_outputs: got %h want 0", dut_bundle());
        else n_pass++;
        n_total++;
        if (stall_out !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_out);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (dut_bundle() !== 153'd0) $display("FAIL reset_held: got %h want 0", dut_bundle());
        else n_pass++;
        @(negedge clk);
        set_idle();
        rst = 1;
        cycle();
        cycle();
        n_total++;
        if (ex_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", ex_valid);
        else n_pass++;
    endtask

    task automatic test_pass_through();
        drive_id(32'h0043_0820, C_RTYP, 32'h0000_0104, 32'd2, 32'd1);
        #1;
        n_total++;
        if (stall_out !== 1'b0) $display("FAIL pass_stall: got %b want 0", stall_out);
        else n_pass++;
        cycle();
        n_total++;
        if ({ex_valid, ex_rs, ex_rt, ex_rd} !== {1'b1, 5'd2, 5'd3, 5'd1})
            $display("FAIL pass_fields: got %b %0d %0d %0d want 1 2 3 1", ex_valid, ex_rs, ex_rt, ex_rd);
        else n_pass++;
        n_total++;
        if ({ex_rs_data, ex_rt_data, ex_ctrl, ex_pc4} !== {32'd2, 32'd1, C_RTYP, 32'h104})
            $display("FAIL pass_data: got %h %h %h %h want 2 1 10a 104",
                     ex_rs_data, ex_rt_data, ex_ctrl, ex_pc4);
        else n_pass++;
    endtask

    task automatic test_bypass();
        // add $1,$5,$6
        drive_id(32'h00A6_0820, C_RTYP, 32'h108, 32'h10, 32'h20);
        wb_regwrite = 1; wb_reg = 5; wb_data = 32'hABCD;
        cycle();
        n_total++;
        if (ex_rs_data !== 32'hABCD) $display("FAIL bypass_rs: got %h want abcd", ex_rs_data);
        else n_pass++;
        wb_reg = 6; wb_data = 32'h5A5A;
        cycle();
        n_total++;
        if ({ex_rs_data, ex_rt_data} !== {32'h10, 32'h5A5A})
            $display("FAIL bypass_rt: got %h %h want 10 5a5a", ex_rs_data, ex_rt_data);
        else n_pass++;
        wb_reg = 5; wb_data = 32'hABCD; wb_regwrite = 0;
        cycle();
        n_total++;
        if (ex_rs_data !== 32'h10) $display("FAIL bypass_off: got %h want 10", ex_rs_data);
        else n_pass++;
    endtask

    task automatic test_load_use();
        drive_id(32'h8C04_0000, C_LW, 32'h200, 32'h0, 32'h0);   // lw $4,0($0)
        cycle();
        drive_id(32'h0087_3020, C_RTYP, 32'h204, 32'h44, 32'h77); // add $6,$4,$7
        #1;
        n_total++;
        if (stall_out !== 1'b1) $display("FAIL loaduse_stall: got %b want 1", stall_out);
        else n_pass++;
        cycle();
        n_total++;
        if ({ex_valid, ex_ctrl} !== 10'd0) $display("FAIL loaduse_bubble: got %b %h want 0 0", ex_valid, ex_ctrl);
        else n_pass++;
        // Load data lands in writeback while the add is re-presented.
        wb_regwrite = 1; wb_reg = 4; wb_data = 32'h4444;
        #1;
        n_total++;
        if (stall_out !== 1'b0) $display("FAIL loaduse_release: got %b want 0", stall_out);
        else n_pass++;
        cycle();
        wb_regwrite = 0;
        n_total++;
        if ({ex_valid, ex_rs, ex_rd, ex_rs_data, ex_rt_data} !== {1'b1, 5'd4, 5'd6, 32'h4444, 32'h77})
            $display("FAIL loaduse_capture: got %b %0d %0d %h %h want 1 4 6 4444 77",
                     ex_valid, ex_rs, ex_rd, ex_rs_data, ex_rt_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive_id(32'h8C04_0000, C_LW, 32'h300, 0, 0);           // lw $4,0($0)
        cycle();
        drive_id(32'h8C85_0000, C_LW, 32'h304, 0, 0);           // lw $5,0($4)
        #1;
        n_total++;
        if (stall_out !== 1'b1) $display("FAIL b2b_stall1: got %b want 1", stall_out);
        else n_pass++;
        cycle();
        cycle();
        n_total++;
        if ({ex_valid, ex_rt, ex_ctrl} !== {1'b1, 5'd5, C_LW})
            $display("FAIL b2b_load2: got %b %0d %h want 1 5 1b0", ex_valid, ex_rt, ex_ctrl);
        else n_pass++;
        drive_id(32'h00A0_3020, C_RTYP, 32'h308, 0, 0);         // add $6,$5,$0
        #1;
        n_total++;
        if (stall_out !== 1'b1) $display("FAIL b2b_stall2: got %b want 1", stall_out);
        else n_pass++;
        cycle();
    endtask

    task automatic test_non_use();
        drive_id(32'h8C04_0000, C_LW, 32'h400, 0, 0);
        cycle();
        drive_id(32'h2124_0001, C_ADDI, 32'h404, 32'h99, 32'h0);  // addi $4,$9,1
        #1;
        n_total++;
        if (stall_out !== 1'b0) $display("FAIL nonuse_stall: got %b want 0", stall_out);
        else n_pass++;
        cycle();
        n_total++;
        if ({ex_valid, ex_rt, ex_imm, ex_rs_data} !== {1'b1, 5'd4, 32'd1, 32'h99})
            $display("FAIL nonuse_capture: got %b %0d %h %h want 1 4 1 99",
                     ex_valid, ex_rt, ex_imm, ex_rs_data);
        else n_pass++;
    endtask

    task automatic test_flush_imm();
        drive_id(32'h8C04_0000, C_LW, 32'h500, 0, 0);
        cycle();
        drive_id(32'h0087_3020, C_RTYP, 32'h504, 1, 2);
        flush = 1;
        #1;
        n_total++;
        if (stall_out !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall_out);
        else n_pass++;
        cycle();
        flush = 0;
        n_total++;
        if (dut_bundle() !== 153'd0) $display("FAIL flush_bubble: got %h want 0", dut_bundle());
        else n_pass++;
        drive_id(32'h2022_FFFF, C_ADDI, 32'h508, 0, 0);         // addi $2,$1,-1
        cycle();
        n_total++;
        if (ex_imm !== 32'hFFFF_FFFF) $display("FAIL imm_sign: got %h want ffffffff", ex_imm);
        else n_pass++;
        drive_id(32'h3422_FFFF, C_ADDI, 32'h50C, 0, 0);         // ori $2,$1,0xffff
        cycle();
        n_total++;
        if (ex_imm !== 32'h0000_FFFF) $display("FAIL imm_zero: got %h want 0000ffff", ex_imm);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        drive_id(32'h8C04_0000, C_LW, 32'h600, 0, 0);
        cycle();
        drive_id(32'h0087_3020, C_RTYP, 32'h604, 0, 0);
        #2 rst = 0;
        #1;
        model_clear();
        n_total++;
        if ({stall_out, dut_bundle()} !== 154'd0)
            $display("FAIL midstall_reset: got %b %h want 0 0", stall_out, dut_bundle());
        else n_pass++;
        @(negedge clk);
        rst = 1;
        #1;
        n_total++;
        if (stall_out !== 1'b0) $display("FAIL midstall_release: got %b want 0", stall_out);
        else n_pass++;
        cycle();
        n_total++;
        if (ex_valid !== 1'b1) $display("FAIL midstall_capture: got %b want 1", ex_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{6'h00, 6'h04, 6'h23, 6'h08, 6'h0D, 6'h2B};
        for (int i = 0; i < 400; i++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_instr    = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3)), 16'($urandom)};
            id_ctrl     = 9'($urandom);
            id_pc4      = $urandom;
            rd1_in      = $urandom;
            rd2_in      = $urandom;
            wb_regwrite = 1'($urandom);
            wb_reg      = 5'($urandom_range(0, 3));
            wb_data     = $urandom;
            flush       = ($urandom_range(0, 7) == 0);
            #1;
            n_total++;
            if (stall_out !== (ref_hazard() && !flush))
                $display("FAIL rand_stall[%0d]: got %b want %b", i, stall_out, ref_hazard() && !flush);
            else n_pass++;
            cycle();
            n_total++;
            if (dut_bundle() !== model_bundle())
                $display("FAIL rand_ex[%0d]: got %h want %h", i, dut_bundle(), model_bundle());
            else n_pass++;
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        model_clear();
        test_reset();
        test_pass_through();
        test_bypass();
        test_load_use();
        test_back_to_back();
        test_non_use();
        test_flush_imm();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
